// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and register-file constants
package core_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits with busy lookup for two read ports
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_rf,
    input  logic [AW-1:0] a3,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    output logic          busy1,
    output logic          busy2,
    output logic          any_busy
);
    import core_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Next pending state: writeback clears first, so a same-cycle issue to the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (we_rf) begin
            pend_d[a3] = 1'b0;
        end
        if (issue_valid && (issue_rd != ZERO_ADDR)) begin
            pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Pending register; asynchronous reset drops every outstanding producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Busy lookup: a writeback landing this cycle hides busy only when it is also forwarded.
    always_comb begin
        busy1    = pend_q[a1] && !(BYPASS && we_rf && (a3 == a1));
        busy2    = pend_q[a2] && !(BYPASS && we_rf && (a3 == a2));
        any_busy = |pend_q;
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write bypass and pending scoreboard
module regfile_sb #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int NREGS  = core_pkg::NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_rf,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2,
    output logic            any_busy
);
    import core_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next storage state: only a non-zero writeback address updates a register.
    always_comb begin
        regs_d = regs_q;
        if (we_rf && (a3 != ZERO_ADDR)) begin
            regs_d[a3] = wd;
        end
        regs_d[0] = '0;
    end

    // Storage flops; asynchronous reset clears every register, so no write lands while reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 and reset read zero; same-cycle writeback is forwarded when bypass is enabled.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rst_n && (a1 != ZERO_ADDR)) begin
            rd1 = (BYPASS && we_rf && (a3 == a1)) ? wd : regs_q[a1];
        end
        if (rst_n && (a2 != ZERO_ADDR)) begin
            rd2 = (BYPASS && we_rf && (a3 == a2)) ? wd : regs_q[a2];
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_rf       (we_rf),
        .a3          (a3),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .a1          (a1),
        .a2          (a2),
        .busy1       (busy1),
        .busy2       (busy2),
        .any_busy    (any_busy)
    );

endmodule
